// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants, segment table and buffer type for the seven-segment path
package ssd_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; element n is the pattern for hex value n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  en;
    logic [3:0]  blink;
    logic [3:0]  dp;
  } disp_buf_t;

endpackage

// File: rtl/hex_to_ssd.sv
// rtl/hex_to_ssd.sv - hex nibble to active-low seven-segment pattern
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - four-digit multiplexed scan with guard blanking, blink,
// leading-zero suppression and frame-synchronous buffer updates
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int GUARD_CYC    = 1_000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  blink_en,
  input  logic [3:0]  dp,
  input  logic        lz_blank,
  output logic [6:0]  CATHODE,
  output logic        DP_N,
  output logic [3:0]  ANODE,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYC);
  localparam logic [FR_W-1:0]  FR_LAST   = FR_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [FR_W-1:0]  r_frame_cnt;
  logic             r_blink;
  disp_buf_t        r_pend;
  disp_buf_t        r_act;
  logic             r_pend_valid;
  logic             r_act_valid;
  logic [3:0]       r_anode;
  logic [6:0]       r_cathode;
  logic             r_dp_n;
  logic             r_frame_done;

  logic             w_tick;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_idx_nxt;
  disp_buf_t        w_load_buf;
  disp_buf_t        w_pend_nxt;
  disp_buf_t        w_act_nxt;
  logic             w_pend_valid_nxt;
  logic             w_act_valid_nxt;
  logic [FR_W-1:0]  w_frame_cnt_nxt;
  logic             w_blink_nxt;
  logic [3:0]       w_lz_sup;
  logic [3:0]       w_visible;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic [3:0]       w_anode_nxt;
  logic [6:0]       w_cathode_nxt;
  logic             w_dp_n_nxt;

  always_comb begin
    w_tick           = (r_cnt == CNT_LAST);
    w_wrap           = w_tick && (r_idx == 2'd3);
    w_cnt_nxt        = w_tick ? '0 : r_cnt + 1'b1;
    w_idx_nxt        = w_tick ? r_idx + 2'd1 : r_idx;
    w_load_buf       = {digits, digit_en, blink_en, dp};
    w_pend_nxt       = load ? w_load_buf : r_pend;
    w_pend_valid_nxt = load | r_pend_valid;
    w_act_nxt        = r_act;
    w_act_valid_nxt  = r_act_valid;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_blink_nxt      = r_blink;
    // A load in the boundary cycle is folded into this same swap.
    if (w_wrap) begin
      if (w_pend_valid_nxt) begin
        w_act_nxt        = w_pend_nxt;
        w_act_valid_nxt  = 1'b1;
        w_pend_valid_nxt = 1'b0;
      end
      if (r_frame_cnt == FR_LAST) begin
        w_frame_cnt_nxt = '0;
        w_blink_nxt     = ~r_blink;
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_lz_sup = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      w_lz_sup[i] = lz_blank && (w_act_nxt.digits[4*i +: 4] == 4'd0);
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (w_act_nxt.en[j] && (w_act_nxt.digits[4*j +: 4] != 4'd0)) begin
          w_lz_sup[i] = 1'b0;
        end
      end
    end
    w_visible = w_act_nxt.en & ~(w_act_nxt.blink & {4{w_blink_nxt}}) & ~w_lz_sup;
    w_nib     = w_act_nxt.digits[{w_idx_nxt, 2'b00} +: 4];
  end

  hex_to_ssd u_hex (
    .i_nibble (w_nib),
    .o_seg    (w_seg)
  );

  // Outputs are computed from next-state so the registered drive lines up with
  // the slot count; nothing is driven until a buffer has actually been loaded.
  always_comb begin
    w_anode_nxt   = ANODE_OFF;
    w_cathode_nxt = SEG_OFF;
    w_dp_n_nxt    = 1'b1;
    if (w_act_valid_nxt && !(w_cnt_nxt < CNT_GUARD)) begin
      w_anode_nxt = ~(4'b0001 << w_idx_nxt);
      if (w_visible[w_idx_nxt]) begin
        w_cathode_nxt = w_seg;
        w_dp_n_nxt    = ~w_act_nxt.dp[w_idx_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_frame_cnt  <= '0;
      r_blink      <= 1'b0;
      r_pend       <= '0;
      r_act        <= '0;
      r_pend_valid <= 1'b0;
      r_act_valid  <= 1'b0;
      r_anode      <= ANODE_OFF;
      r_cathode    <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_blink      <= w_blink_nxt;
      r_pend       <= w_pend_nxt;
      r_act        <= w_act_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_act_valid  <= w_act_valid_nxt;
      r_anode      <= w_anode_nxt;
      r_cathode    <= w_cathode_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_frame_done <= w_wrap;
    end
  end

  assign ANODE      = r_anode;
  assign CATHODE    = r_cathode;
  assign DP_N       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - scoreboard bench for ssd_scan_driver (8-cycle slots, 2-cycle guard, 2-frame blink)
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic [3:0]  dp;
  logic        lz_blank;
  logic [6:0]  CATHODE;
  logic        DP_N;
  logic [3:0]  ANODE;
  logic        frame_done;

  ssd_scan_driver #(
    .REFRESH_DIV  (8),
    .GUARD_CYC    (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits     (digits),
    .digit_en   (digit_en),
    .blink_en   (blink_en),
    .dp         (dp),
    .lz_blank   (lz_blank),
    .CATHODE    (CATHODE),
    .DP_N       (DP_N),
    .ANODE      (ANODE),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       fd;
    logic [3:0] an;
    logic [6:0] ca;
    logic       dpn;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t m_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_cmp++;
      if (m_e.cyc < cyc) begin
        n_bad++;
        $display("FAIL late_entry cyc=%0d got cyc %0d required cyc %0d", cyc, cyc, m_e.cyc);
      end else if ({frame_done, ANODE, CATHODE, DP_N} !== {m_e.fd, m_e.an, m_e.ca, m_e.dpn}) begin
        n_bad++;
        $display("FAIL scan cyc=%0d fd/an/cath/dpn got %b/%b/%b/%b required %b/%b/%b/%b",
                 cyc, frame_done, ANODE, CATHODE, DP_N, m_e.fd, m_e.an, m_e.ca, m_e.dpn);
      end
    end
  end

  // Frame n starts (frame_done high) 32 cycles after the previous one; first at 35.
  function automatic int fb(input int n);
    return 35 + 32 * n;
  endfunction

  task automatic push_frame(input int base, input bit on, input logic [6:0] c3, input logic [6:0] c2,
                            input logic [6:0] c1, input logic [6:0] c0, input logic [3:0] dpn, input int nk);
    logic [6:0] cs [4];
    exp_t e;
    cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
    for (int k = 0; k < nk; k++) begin
      int s;
      int c;
      s = k / 8;
      c = k % 8;
      e.cyc = base + k;
      e.fd  = (k == 0);
      if (on && c >= 2) begin
        e.an  = ~(4'b0001 << s);
        e.ca  = cs[s];
        e.dpn = dpn[s];
      end else begin
        e.an  = 4'hF;
        e.ca  = 7'h7F;
        e.dpn = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  task automatic push_off(input int c);
    exp_t e;
    e.cyc = c; e.fd = 1'b0; e.an = 4'hF; e.ca = 7'h7F; e.dpn = 1'b1;
    q.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] bl, input logic [3:0] p);
    digits = d; digit_en = en; blink_en = bl; dp = p; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    int r2;
    reset = 1'b0; load = 1'b0; digits = '0; digit_en = '0; blink_en = '0; dp = '0; lz_blank = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    push_off(3);
    push_frame(fb(0), 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 32);
    reset = 1'b1;

    at_cyc(fb(0) + 5);
    push_frame(fb(1), 1'b1, 7'h79, 7'h24, 7'h08, 7'h0E, 4'b1011, 32);
    push_frame(fb(2), 1'b1, 7'h79, 7'h24, 7'h08, 7'h0E, 4'b1011, 32);
    do_load(16'h12AF, 4'b1111, 4'b0000, 4'b0100);

    at_cyc(fb(2) + 10);
    push_frame(fb(3), 1'b1, 7'h40, 7'h40, 7'h40, 7'h00, 4'b1111, 32);
    do_load(16'h0000, 4'b1111, 4'b0000, 4'b0000);
    at_cyc(fb(2) + 20);
    do_load(16'h0008, 4'b1111, 4'b0000, 4'b0000);

    at_cyc(fb(3) + 3);
    push_frame(fb(4), 1'b1, 7'h7F, 7'h78, 7'h40, 7'h40, 4'b1111, 32);
    push_frame(fb(5), 1'b1, 7'h40, 7'h78, 7'h40, 7'h40, 4'b1111, 32);
    do_load(16'h0700, 4'b1111, 4'b0000, 4'b0000);
    at_cyc(fb(4) - 1);
    lz_blank = 1'b1;
    at_cyc(fb(5) - 1);
    lz_blank = 1'b0;

    at_cyc(fb(5) + 3);
    push_frame(fb(6),  1'b1, 7'h19, 7'h30, 7'h24, 7'h7F, 4'b1111, 32);
    push_frame(fb(7),  1'b1, 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111, 32);
    push_frame(fb(8),  1'b1, 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111, 32);
    push_frame(fb(9),  1'b1, 7'h19, 7'h30, 7'h24, 7'h7F, 4'b1111, 32);
    push_frame(fb(10), 1'b1, 7'h19, 7'h30, 7'h24, 7'h7F, 4'b1111, 32);
    do_load(16'h4321, 4'b1111, 4'b0001, 4'b0000);

    at_cyc(fb(11) - 1);
    r2 = fb(12) + 15;
    push_frame(fb(11), 1'b1, 7'h46, 7'h40, 7'h21, 7'h06, 4'b0110, 32);
    push_frame(fb(12), 1'b1, 7'h46, 7'h40, 7'h21, 7'h06, 4'b0110, 14);
    push_off(fb(12) + 14);
    push_off(fb(12) + 15);
    push_off(r2 + 10);
    push_off(r2 + 20);
    push_frame(r2 + 32, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 32);
    do_load(16'hC0DE, 4'b1111, 4'b0000, 4'b1001);

    at_cyc(fb(12) + 5);
    do_load(16'h1111, 4'b1111, 4'b0000, 4'b0000);
    at_cyc(fb(12) + 13);
    reset = 1'b0;
    at_cyc(r2);
    reset = 1'b1;

    at_cyc(r2 + 32 + 34);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending entries required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog got cyc %0d required completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
